// File: rtl/tiny_dnn_pkg.sv
// Shared types, default widths and the saturation helper for the tiny DNN core array.
package tiny_dnn_pkg;

    localparam int unsigned DW_DEF    = 16;
    localparam int unsigned FRAC_DEF  = 8;
    localparam int unsigned ACC_W_DEF = 32;

    typedef logic signed [DW_DEF-1:0]    data_t;
    typedef logic signed [ACC_W_DEF-1:0] acc_t;

    // Clamp an accumulator value (already in output Q format) to the signed data range.
    function automatic data_t sat_dw(input acc_t a);
        data_t r;
        if (a[ACC_W_DEF-1:DW_DEF-1] == {(ACC_W_DEF-DW_DEF+1){a[ACC_W_DEF-1]}}) begin
            r = a[DW_DEF-1:0];
        end else if (a[ACC_W_DEF-1]) begin
            r = {1'b1, {(DW_DEF-1){1'b0}}};
        end else begin
            r = {1'b0, {(DW_DEF-1){1'b1}}};
        end
        return r;
    endfunction

endpackage

// File: rtl/tiny_dnn_mac_lane.sv
// One output channel: private weight RAM, bias register and the second MAC stage.
module tiny_dnn_mac_lane
    import tiny_dnn_pkg::*;
#(
    parameter  int unsigned DW     = DW_DEF,
    parameter  int unsigned FRAC   = FRAC_DEF,
    parameter  int unsigned ACC_W  = ACC_W_DEF,
    parameter  int unsigned WDEPTH = 1024,
    localparam int unsigned AW     = $clog2(WDEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    we_w,
    input  logic                    we_b,
    input  logic [AW-1:0]           waddr,
    input  logic [DW-1:0]           wdata,
    input  logic                    rd_en,
    input  logic [AW-1:0]           ra,
    input  logic                    s1_exec,
    input  logic                    s1_init,
    input  logic signed [DW-1:0]    s1_d,
    output logic signed [ACC_W-1:0] acc,
    output logic signed [DW-1:0]    bias
);

    logic [DW-1:0]           mem [WDEPTH];
    logic signed [DW-1:0]    w_q;
    logic signed [2*DW-1:0]  prod_c;
    logic signed [2*DW-1:0]  prod_sh_c;
    logic signed [ACC_W-1:0] term_c;

    // Weight RAM write port; contents intentionally not reset.
    always_ff @(posedge clk) begin
        if (we_w) begin
            mem[waddr] <= wdata;
        end
    end

    // Stage 1: registered weight read alongside the array's operand register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_q <= '0;
        end else if (rd_en) begin
            w_q <= mem[ra];
        end
    end

    // Stage 2 product: full-width multiply, drop FRAC bits, sign-extend to the accumulator.
    always_comb begin
        prod_c    = s1_d * w_q;
        prod_sh_c = prod_c >>> FRAC;
        term_c    = ACC_W'(prod_sh_c);
    end

    // Accumulator: k_init clears first so a same-cycle exec term becomes the new start value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (s1_init) begin
            acc <= s1_exec ? term_c : '0;
        end else if (s1_exec) begin
            acc <= acc + term_c;
        end
    end

    // Bias register, written by bias-targeted beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bias <= '0;
        end else if (we_b) begin
            bias <= wdata;
        end
    end

endmodule

// File: rtl/tiny_dnn_core_array.sv
// F_NUM MAC lanes on a broadcast operand, lane-grouped weight loading and a
// snapshot-based ready/valid result drain (core 0 first).
module tiny_dnn_core_array
    import tiny_dnn_pkg::*;
#(
    parameter  int unsigned F_NUM  = 16,
    parameter  int unsigned LANES  = 4,
    parameter  int unsigned DW     = DW_DEF,
    parameter  int unsigned FRAC   = FRAC_DEF,
    parameter  int unsigned ACC_W  = ACC_W_DEF,
    parameter  int unsigned WDEPTH = 1024,
    localparam int unsigned AW     = $clog2(WDEPTH),
    localparam int unsigned GW     = (F_NUM / LANES > 1) ? $clog2(F_NUM / LANES) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic                wr_bias,
    input  logic [GW-1:0]       wr_grp,
    input  logic [AW-1:0]       wr_addr,
    input  logic [LANES*DW-1:0] wr_data,
    input  logic                k_init,
    input  logic                exec,
    input  logic [AW-1:0]       ra,
    input  logic [DW-1:0]       d,
    input  logic                k_fin,
    input  logic                en_bias,
    output logic                exec_busy,
    output logic                out_busy,
    output logic                out_valid,
    output logic [DW-1:0]       out_data,
    output logic                out_last,
    input  logic                out_ready,
    output logic                err_ovr
);

    localparam int unsigned CW = (F_NUM > 1) ? $clog2(F_NUM) : 1;

    logic                    wr_fire_c;
    logic                    busy_nxt_c;
    logic                    s1_exec;
    logic                    s1_init;
    logic                    s1_fin;
    logic                    s1_en_bias;
    logic signed [DW-1:0]    d_q;
    logic signed [ACC_W-1:0] acc_w  [F_NUM];
    logic signed [DW-1:0]    bias_w [F_NUM];
    logic [DW-1:0]           sat_c  [F_NUM];
    logic [DW-1:0]           snap   [F_NUM];
    logic [CW-1:0]           idx;
    logic [CW-1:0]           idx_nxt_c;

    // Clamp a widened (acc + bias) sum to the signed DW range.
    function automatic logic [DW-1:0] sat_acc(input logic signed [ACC_W:0] v);
        logic [DW-1:0] r;
        if (v[ACC_W:DW-1] == {(ACC_W-DW+2){v[ACC_W]}}) begin
            r = v[DW-1:0];
        end else if (v[ACC_W]) begin
            r = {1'b1, {(DW-1){1'b0}}};
        end else begin
            r = {1'b0, {(DW-1){1'b1}}};
        end
        return r;
    endfunction

    // Write handshake, next-cycle pipeline occupancy and next drain index.
    always_comb begin
        wr_fire_c  = wr_valid & wr_ready;
        busy_nxt_c = exec | k_init | k_fin | s1_exec | s1_init | s1_fin;
        idx_nxt_c  = idx + CW'(1);
    end

    // Stage 1 control/operand register; busy and write-ready track the pipe contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_exec    <= 1'b0;
            s1_init    <= 1'b0;
            s1_fin     <= 1'b0;
            s1_en_bias <= 1'b0;
            d_q        <= '0;
            exec_busy  <= 1'b0;
            wr_ready   <= 1'b1;
        end else begin
            s1_exec    <= exec;
            s1_init    <= k_init;
            s1_fin     <= k_fin;
            s1_en_bias <= en_bias;
            if (exec) begin
                d_q <= d;
            end
            exec_busy  <= busy_nxt_c;
            wr_ready   <= ~busy_nxt_c;
        end
    end

    for (genvar c = 0; c < F_NUM; c++) begin : g_core
        logic                    we_w_c;
        logic                    we_b_c;
        logic signed [ACC_W:0]   sum_c;

        // Beat decode for this core and its biased, saturated kernel result.
        always_comb begin
            we_b_c   = wr_fire_c & wr_bias & (wr_grp == GW'(c / LANES));
            we_w_c   = wr_fire_c & ~wr_bias & (wr_grp == GW'(c / LANES));
            sum_c    = (ACC_W+1)'(acc_w[c]) + (s1_en_bias ? (ACC_W+1)'(bias_w[c]) : '0);
            sat_c[c] = sat_acc(sum_c);
        end

        tiny_dnn_mac_lane #(
            .DW     (DW),
            .FRAC   (FRAC),
            .ACC_W  (ACC_W),
            .WDEPTH (WDEPTH)
        ) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .we_w    (we_w_c),
            .we_b    (we_b_c),
            .waddr   (wr_addr),
            .wdata   (wr_data[(c % LANES) * DW +: DW]),
            .rd_en   (exec),
            .ra      (ra),
            .s1_exec (s1_exec),
            .s1_init (s1_init),
            .s1_d    (d_q),
            .acc     (acc_w[c]),
            .bias    (bias_w[c])
        );
    end

    // Snapshot load on k_fin, overrun flag, and the core-ordered drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < F_NUM; i++) begin
                snap[i] <= '0;
            end
            idx       <= '0;
            out_busy  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            err_ovr   <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                if (out_last) begin
                    idx       <= '0;
                    out_busy  <= 1'b0;
                    out_valid <= 1'b0;
                    out_data  <= '0;
                    out_last  <= 1'b0;
                end else begin
                    idx      <= idx_nxt_c;
                    out_data <= snap[idx_nxt_c];
                    out_last <= (idx_nxt_c == CW'(F_NUM - 1));
                end
            end
            if (s1_fin) begin
                if (out_busy) begin
                    err_ovr <= 1'b1;
                end else begin
                    for (int unsigned i = 0; i < F_NUM; i++) begin
                        snap[i] <= sat_c[i];
                    end
                    idx       <= '0;
                    out_busy  <= 1'b1;
                    out_valid <= 1'b1;
                    out_data  <= sat_c[0];
                    out_last  <= (F_NUM == 1);
                end
            end
        end
    end

endmodule

// File: tb/tb_tiny_dnn_core_array.sv
// Directed self-checking bench for tiny_dnn_core_array (default parameters).
module tb_tiny_dnn_core_array;

    logic        clk;
    logic        rst_n;
    logic        wr_valid;
    logic        wr_ready;
    logic        wr_bias;
    logic [1:0]  wr_grp;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic        k_init;
    logic        exec;
    logic [9:0]  ra;
    logic [15:0] d;
    logic        k_fin;
    logic        en_bias;
    logic        exec_busy;
    logic        out_busy;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_last;
    logic        out_ready;
    logic        err_ovr;

    int          n_checks;
    int          n_errors;
    logic [15:0] vec [16];
    logic [15:0] exp_v [16];

    tiny_dnn_core_array dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_bias   (wr_bias),
        .wr_grp    (wr_grp),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .k_init    (k_init),
        .exec      (exec),
        .ra        (ra),
        .d         (d),
        .k_fin     (k_fin),
        .en_bias   (en_bias),
        .exec_busy (exec_busy),
        .out_busy  (out_busy),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .err_ovr   (err_ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Load vec[] into all 16 cores (weights at addr, or biases), one beat per group.
    task automatic write_cores(input logic is_bias, input logic [9:0] addr);
        for (int g = 0; g < 4; g++) begin
            int w;
            w = 0;
            @(negedge clk);
            while (!wr_ready && w < 20) begin
                @(negedge clk);
                w++;
            end
            check("wr_ready_wait", 32'(wr_ready), 32'd1);
            wr_valid = 1'b1;
            wr_bias  = is_bias;
            wr_grp   = 2'(g);
            wr_addr  = addr;
            wr_data  = {vec[g*4+3], vec[g*4+2], vec[g*4+1], vec[g*4]};
            @(negedge clk);
            wr_valid = 1'b0;
            wr_bias  = 1'b0;
        end
    endtask

    task automatic fill_vec(input logic [15:0] v);
        for (int i = 0; i < 16; i++) vec[i] = v;
    endtask

    task automatic fill_exp(input logic [15:0] v);
        for (int i = 0; i < 16; i++) exp_v[i] = v;
    endtask

    // k_init with the first of n execs, k_fin the cycle after the last exec.
    task automatic run_kernel(input int n, input logic [15:0] dval, input logic [9:0] addr,
                              input logic eb);
        @(negedge clk);
        k_init = 1'b1;
        exec   = 1'b1;
        d      = dval;
        ra     = addr;
        @(negedge clk);
        k_init = 1'b0;
        check("exec_busy_run", 32'(exec_busy), 32'd1);
        check("wr_ready_blocked", 32'(wr_ready), 32'd0);
        for (int i = 1; i < n; i++) @(negedge clk);
        exec    = 1'b0;
        k_fin   = 1'b1;
        en_bias = eb;
        @(negedge clk);
        k_fin   = 1'b0;
        en_bias = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int w;
        w = 0;
        while (!out_valid && w < 20) begin
            @(negedge clk);
            w++;
        end
        check(tag, 32'(out_valid), 32'd1);
    endtask

    // Drain with out_ready held high, comparing against exp_v[].
    task automatic drain_check(input string tag);
        wait_valid({tag, "_valid"});
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("%s_valid%0d", tag, i), 32'(out_valid), 32'd1);
            check($sformatf("%s_data%0d", tag, i), 32'(out_data), 32'(exp_v[i]));
            check($sformatf("%s_last%0d", tag, i), 32'(out_last), 32'(i == 15));
            @(negedge clk);
        end
        out_ready = 1'b0;
        check({tag, "_done_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_done_busy"}, 32'(out_busy), 32'd0);
    endtask

    initial begin
        int beat;
        int cyc;
        logic [3:0] pat;

        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        wr_valid  = 1'b0;
        wr_bias   = 1'b0;
        wr_grp    = '0;
        wr_addr   = '0;
        wr_data   = '0;
        k_init    = 1'b0;
        exec      = 1'b0;
        ra        = '0;
        d         = '0;
        k_fin     = 1'b0;
        en_bias   = 1'b0;
        out_ready = 1'b0;

        // Reset state
        #22;
        check("rst_wr_ready", 32'(wr_ready), 32'd1);
        check("rst_exec_busy", 32'(exec_busy), 32'd0);
        check("rst_out_busy", 32'(out_busy), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_err_ovr", 32'(err_ovr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: w=1.0, d=2.0, three execs -> 6.0 everywhere
        fill_vec(16'h0100);
        write_cores(1'b0, 10'd0);
        run_kernel(3, 16'h0200, 10'd0, 1'b0);
        fill_exp(16'h0600);
        drain_check("t1");

        // 2: bias[k] = k*0.5 with a zero-operand exec
        for (int i = 0; i < 16; i++) vec[i] = 16'(i * 16'h0080);
        write_cores(1'b1, 10'd0);
        run_kernel(1, 16'h0000, 10'd0, 1'b1);
        for (int i = 0; i < 16; i++) exp_v[i] = 16'(i * 16'h0080);
        drain_check("t2b");
        run_kernel(1, 16'h0000, 10'd0, 1'b0);
        fill_exp(16'h0000);
        drain_check("t2n");

        // 3: saturation both directions (127.0 * +/-127.0, four terms)
        fill_vec(16'h7F00);
        write_cores(1'b0, 10'd5);
        run_kernel(4, 16'h7F00, 10'd5, 1'b0);
        fill_exp(16'h7FFF);
        drain_check("t3p");
        run_kernel(4, 16'h8100, 10'd5, 1'b0);
        fill_exp(16'h8000);
        drain_check("t3n");

        // 4: backpressure, distinct per-core values (c+1).0
        for (int i = 0; i < 16; i++) vec[i] = 16'((i + 1) * 16'h0100);
        write_cores(1'b0, 10'd1);
        run_kernel(1, 16'h0100, 10'd1, 1'b0);
        for (int i = 0; i < 16; i++) exp_v[i] = 16'((i + 1) * 16'h0100);
        wait_valid("t4_valid");
        pat  = 4'b1001;
        beat = 0;
        cyc  = 0;
        while (beat < 16 && cyc < 200) begin
            out_ready = pat[cyc % 4];
            if (out_valid) begin
                check($sformatf("t4_data%0d", beat), 32'(out_data), 32'(exp_v[beat]));
                if (out_ready) begin
                    check($sformatf("t4_last%0d", beat), 32'(out_last), 32'(beat == 15));
                    beat++;
                end
            end
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        check("t4_beats", 32'(beat), 32'd16);
        for (int i = 0; i < 3; i++) begin
            check("t4_no_extra", 32'(out_valid), 32'd0);
            @(negedge clk);
        end
        check("t4_no_ovr", 32'(err_ovr), 32'd0);

        // 5: overrun while the first snapshot is still pending
        run_kernel(1, 16'h0100, 10'd1, 1'b0);
        wait_valid("t5_valid");
        run_kernel(1, 16'h0200, 10'd0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("t5_err_ovr", 32'(err_ovr), 32'd1);
        drain_check("t5");
        check("t5_err_sticky", 32'(err_ovr), 32'd1);

        // 6a: reset mid-drain
        run_kernel(1, 16'h0100, 10'd1, 1'b0);
        wait_valid("t6_valid");
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        out_ready = 1'b0;
        check("t6_mid_data", 32'(out_data), 32'h0400);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 32'(out_valid), 32'd0);
        check("t6_rst_data", 32'(out_data), 32'd0);
        check("t6_rst_busy", 32'(out_busy), 32'd0);
        check("t6_rst_ovr", 32'(err_ovr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 6b: reset mid-exec
        @(negedge clk);
        k_init = 1'b1;
        exec   = 1'b1;
        d      = 16'h0100;
        ra     = 10'd1;
        @(negedge clk);
        k_init = 1'b0;
        check("t6_exec_busy", 32'(exec_busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_exec_busy", 32'(exec_busy), 32'd0);
        check("t6_rst_wr_ready", 32'(wr_ready), 32'd1);
        exec = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("t6_no_stray_valid", 32'(out_valid), 32'd0);

        // 6c: fresh kernel after reset; biases are back to zero
        fill_vec(16'h0100);
        write_cores(1'b0, 10'd0);
        run_kernel(3, 16'h0200, 10'd0, 1'b1);
        fill_exp(16'h0600);
        drain_check("t6c");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
